// File: rtl/rv_fetch_unit.sv
// rtl/rv_fetch_unit.sv - instruction fetch stage: PC owner, credit-limited imem requests, instruction buffer, redirect/squash
module rv_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter int          CNT_W     = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  localparam int             PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {S_RUN, S_FAULT, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;
  logic [31:0]        fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;

  logic [31:0]        ent_pc_q    [BUF_DEPTH];
  logic [31:0]        ent_instr_q [BUF_DEPTH];
  logic               ent_fault_q [BUF_DEPTH];

  logic               credit_ok;
  logic               req_fire;
  logic               pop;
  logic               push;
  logic [31:0]        push_pc;
  logic [31:0]        push_instr;
  logic               push_fault;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both in-flight requests and buffered entries, so a response always has a slot.
  assign credit_ok      = ({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_W;
  assign imem_req_valid = !rst && (state_q == S_RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign if_valid       = !rst && (count_q != '0) && !redirect_valid;
  assign if_pc          = ent_pc_q[head_q];
  assign if_instr       = ent_instr_q[head_q];
  assign if_fault       = ent_fault_q[head_q];
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pop            = if_valid && if_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    fault_pc_d = fault_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    push       = 1'b0;
    push_pc    = rsp_pc_q;
    push_instr = imem_rsp_data;
    push_fault = 1'b0;

    if (redirect_valid) begin
      // Everything still in flight, minus a response landing right now, becomes stale.
      outst_d    = outst_q - CNT_W'(imem_rsp_valid);
      drop_d     = outst_q - CNT_W'(imem_rsp_valid);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fault_pc_d = redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d     = redirect_pc;
        rsp_pc_d = redirect_pc;
        state_d  = S_RUN;
      end else begin
        state_d  = S_FAULT;
      end
    end else begin
      outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (req_fire) pc_d = pc_q + 32'd4;
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
      if (state_q == S_FAULT && drop_q == '0) begin
        push       = 1'b1;
        push_pc    = fault_pc_q;
        push_instr = NOP;
        push_fault = 1'b1;
        state_d    = S_HALT;
      end
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      fault_pc_q <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      fault_pc_q <= fault_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
        ent_fault_q[i] <= 1'b0;
      end
    end else if (push) begin
      ent_pc_q[tail_q]    <= push_pc;
      ent_instr_q[tail_q] <= push_instr;
      ent_fault_q[tail_q] <= push_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count_q == CNT_W'(BUF_DEPTH)));
  end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb/tb_rv_fetch_unit.sv - randomized bench for rv_fetch_unit against a stream-level fetch model
module tb_rv_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  rv_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef enum {M_RUN, M_FAULT, M_DEAD} mode_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          rdy_pct = 100;
  int          dec_pct = 100;
  int          idle = 0;
  mode_t       mode = M_RUN;
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] exp_deliver = 32'h0;
  logic [31:0] fault_tgt = 32'h0;
  mreq_t       memq[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_instr_log[$];
  logic [31:0] pop_fault_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc_log.delete();
    pop_instr_log.delete();
    pop_fault_log.delete();
    idle = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_fault", {31'b0, if_fault}, 32'h0);
    memq.delete();
    last_due       = 0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    mode        = M_RUN;
    exp_fetch   = 32'h0;
    exp_deliver = 32'h0;
    clear_logs();
  endtask

  // One cycle: drive inputs at the falling edge, then judge what the next rising edge will do.
  task automatic step(input bit redir, input logic [31:0] tgt);
    bit fire;
    int due;
    @(negedge clk);
    cyc++;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    if_ready       = ($urandom_range(0, 99) < dec_pct);
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : $urandom;
    #1;
    if (redirect_valid) begin
      chk("redir_no_req", {31'b0, imem_req_valid}, 32'h0);
      chk("redir_no_ifvalid", {31'b0, if_valid}, 32'h0);
      clear_logs();
      if (redirect_pc[1:0] == 2'b00) begin
        mode        = M_RUN;
        exp_fetch   = redirect_pc;
        exp_deliver = redirect_pc;
      end else begin
        mode      = M_FAULT;
        fault_tgt = redirect_pc;
      end
    end else begin
      fire = imem_req_valid && imem_req_ready;
      if (mode != M_RUN) chk("no_req_after_fault", {31'b0, imem_req_valid}, 32'h0);
      if (fire) begin
        chk("req_addr", imem_req_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        req_log.push_back(imem_req_addr);
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        memq.push_back('{addr: imem_req_addr, due: due});
      end
      if (if_valid && if_ready) begin
        case (mode)
          M_RUN: begin
            chk("pop_pc", if_pc, exp_deliver);
            chk("pop_instr", if_instr, mem_word(exp_deliver));
            chk("pop_fault", {31'b0, if_fault}, 32'h0);
            exp_deliver = exp_deliver + 32'd4;
          end
          M_FAULT: begin
            chk("fault_pc", if_pc, fault_tgt);
            chk("fault_instr", if_instr, 32'h0000_0013);
            chk("fault_flag", {31'b0, if_fault}, 32'h1);
            mode = M_DEAD;
          end
          default: chk("pop_after_fault", {31'b0, if_valid}, 32'h0);
        endcase
        pop_pc_log.push_back(if_pc);
        pop_instr_log.push_back(if_instr);
        pop_fault_log.push_back({31'b0, if_fault});
        idle = 0;
      end else if (if_ready && mode != M_DEAD) begin
        idle++;
        if (idle > 60) begin
          chk("progress_idle_cycles", idle, 32'h0);
          idle = 0;
        end
      end
      chk("in_flight_cap", {31'b0, memq.size() <= 2}, 32'h1);
    end
  endtask

  task automatic run_until_pops(input int n, input string name);
    int k = 0;
    while (pop_pc_log.size() < n && k < 200) begin
      step(1'b0, 32'h0);
      k++;
    end
    chk(name, pop_pc_log.size(), n);
  endtask

  task automatic run_until_reqs(input int n, input string name);
    int k = 0;
    while (req_log.size() < n && k < 200) begin
      step(1'b0, 32'h0);
      k++;
    end
    chk(name, {31'b0, req_log.size() >= n}, 32'h1);
  endtask

  initial begin
    logic [31:0] tgt;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    do_reset();

    // sequential fetch, 1-cycle memory
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100;
    run_until_pops(4, "p1_pops");
    chk("p1_req0", req_log[0], 32'h0);
    chk("p1_req1", req_log[1], 32'h4);
    chk("p1_pop0_pc", pop_pc_log[0], 32'h0);
    chk("p1_pop0_instr", pop_instr_log[0], 32'h0050_0093);
    chk("p1_pop1_pc", pop_pc_log[1], 32'h4);

    // decode stalled: credit cap stops requests
    do_reset();
    dec_pct = 0;
    repeat (10) step(1'b0, 32'h0);
    chk("p2_req_low", {31'b0, imem_req_valid}, 32'h0);
    chk("p2_if_valid", {31'b0, if_valid}, 32'h1);
    chk("p2_req_count", req_log.size(), 32'd2);
    dec_pct = 100;
    run_until_pops(3, "p2_pops");
    chk("p2_pop0", pop_pc_log[0], 32'h0);
    chk("p2_pop1", pop_pc_log[1], 32'h4);
    chk("p2_pop2", pop_pc_log[2], 32'h8);

    // 3-cycle memory, redirect with two requests in flight
    do_reset();
    lat_min = 3; lat_max = 3; dec_pct = 0;
    repeat (3) step(1'b0, 32'h0);
    step(1'b1, 32'h100);
    dec_pct = 100;
    run_until_pops(2, "p3_pops");
    chk("p3_pop0", pop_pc_log[0], 32'h100);
    chk("p3_pop1", pop_pc_log[1], 32'h104);

    // redirect coinciding with a response and a ready head
    do_reset();
    lat_min = 1; lat_max = 1; dec_pct = 100;
    repeat (2) step(1'b0, 32'h0);
    step(1'b1, 32'h40);
    run_until_pops(1, "p4_pops");
    chk("p4_req0", req_log[0], 32'h40);
    chk("p4_pop0", pop_pc_log[0], 32'h40);

    // misaligned target, then recovery
    step(1'b1, 32'h102);
    run_until_pops(1, "p5_pops");
    chk("p5_fault_pc", pop_pc_log[0], 32'h102);
    chk("p5_fault_instr", pop_instr_log[0], 32'h13);
    chk("p5_fault_flag", pop_fault_log[0], 32'h1);
    repeat (10) step(1'b0, 32'h0);
    chk("p5_no_reqs", req_log.size(), 32'd0);
    step(1'b1, 32'h200);
    run_until_reqs(1, "p5_resume");
    chk("p5_req0", req_log[0], 32'h200);

    // PC wrap
    step(1'b1, 32'hFFFF_FFF8);
    run_until_reqs(3, "p6_reqs");
    chk("p6_req0", req_log[0], 32'hFFFF_FFF8);
    chk("p6_req1", req_log[1], 32'hFFFF_FFFC);
    chk("p6_req2", req_log[2], 32'h0000_0000);
    run_until_pops(3, "p6_pops");
    chk("p6_pop2", pop_pc_log[2], 32'h0);

    // randomized traffic with redirects and a mid-stream reset
    lat_min = 1; lat_max = 4; dec_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) rdy_pct = $urandom_range(50, 100);
      if (i == 1500) do_reset();
      if ($urandom_range(0, 14) == 0) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                          : ($urandom & 32'h0000_0FFC);
        if ($urandom_range(0, 4) == 0) tgt = tgt | 32'($urandom_range(1, 3));
        step(1'b1, tgt);
      end else begin
        step(1'b0, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
